// File: rtl/demux_ctrl_pkg.sv
// Shared definitions for the 1-to-4 demux sequencing controller:
// FSM state encoding, mode codes and small one-hot helpers.
package demux_ctrl_pkg;

  localparam int NUM_DEST = 4;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  // Controller states (plain constants so the encoding stays fixed)
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARM   = 2'd1;
  localparam logic [1:0] ST_XFER  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  // True when exactly one bit of the select code is set
  function automatic logic onehot_legal(input logic [3:0] code);
    return (code != 4'd0) && ((code & (code - 4'd1)) == 4'd0);
  endfunction

  // One-hot select code for a destination index
  function automatic logic [3:0] onehot_dest(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/demux_out_reg_v.sv
// One-entry output register: holds the beat presented to the demux.
// A load always wins over a retire, so accept+retire in one cycle
// keeps the register full with the new beat.
module demux_out_reg_v #(
  parameter int DATA_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              retire,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q,
  output logic              full
);

  // Data capture and full flag; reset discards any held beat
  always_ff @(posedge clk) begin
    if (rst) begin
      q    <= '0;
      full <= 1'b0;
    end else if (load) begin
      q    <= d;
      full <= 1'b1;
    end else if (retire) begin
      full <= 1'b0;
    end else begin
      full <= full;
    end
  end

endmodule

// File: rtl/demux_1_4_ctrl_v.sv
// Sequencing controller for the 1-to-4 demux: arms a destination
// (round-robin or software one-hot select), moves up to BURST_LEN beats
// through the output register, then drains and re-arms.
module demux_1_4_ctrl_v
  import demux_ctrl_pkg::*;
#(
  parameter int DATA_W    = 1,
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_mode,
  input  logic [3:0]        i_sel_code,
  input  logic              i_a_valid,
  input  logic [DATA_W-1:0] i_a,
  input  logic              i_a_last,
  output logic              o_a_ready,
  output logic [3:0]        o_code,
  output logic [DATA_W-1:0] o_data,
  output logic [3:0]        o_valid,
  input  logic [3:0]        i_ready,
  output logic              o_busy,
  output logic              o_err
);

  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(BURST_LEN);

  logic [1:0]       state_r;
  logic [1:0]       ptr_r;
  logic [CNT_W-1:0] cnt_r;
  logic [3:0]       code_r;
  logic             mode_r;
  logic             err_r;

  logic full_s;
  logic retire_s;
  logic a_ready_s;
  logic accept_s;
  logic end_burst_s;
  logic drain_done_s;

  // Handshake decode: only the armed destination's ready can retire the beat
  always_comb begin
    retire_s = full_s && ((code_r & i_ready) != 4'd0);
    if (state_r == ST_XFER) begin
      a_ready_s = (!full_s || retire_s) && (cnt_r < BURST_MAX);
    end else begin
      a_ready_s = 1'b0;
    end
    accept_s     = i_a_valid && a_ready_s;
    end_burst_s  = accept_s && (i_a_last || ((cnt_r + CNT_W'(1)) == BURST_MAX));
    drain_done_s = !full_s || retire_s;
  end

  // Controller FSM with destination pointer, burst counter and sticky error
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= ST_IDLE;
      ptr_r   <= 2'd0;
      cnt_r   <= '0;
      code_r  <= 4'd0;
      mode_r  <= MODE_RR;
      err_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (i_a_valid) begin
            state_r <= ST_ARM;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ARM: begin
          if (i_mode == MODE_FIXED) begin
            if (onehot_legal(i_sel_code)) begin
              code_r  <= i_sel_code;
              cnt_r   <= '0;
              mode_r  <= MODE_FIXED;
              state_r <= ST_XFER;
            end else begin
              // Illegal select: flag it, consume nothing, try again later
              err_r   <= 1'b1;
              state_r <= ST_IDLE;
            end
          end else begin
            code_r  <= onehot_dest(ptr_r);
            cnt_r   <= '0;
            mode_r  <= MODE_RR;
            state_r <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (accept_s) begin
            cnt_r <= cnt_r + CNT_W'(1);
            if (end_burst_s) begin
              state_r <= ST_DRAIN;
            end else begin
              state_r <= ST_XFER;
            end
          end else begin
            state_r <= ST_XFER;
          end
        end
        ST_DRAIN: begin
          if (drain_done_s) begin
            // Mode is the one latched at ARM, so late i_mode changes are ignored
            if (mode_r == MODE_RR) begin
              ptr_r <= ptr_r + 2'd1;
            end else begin
              ptr_r <= ptr_r;
            end
            code_r <= 4'd0;
            if (i_a_valid) begin
              state_r <= ST_ARM;
            end else begin
              state_r <= ST_IDLE;
            end
          end else begin
            state_r <= ST_DRAIN;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          code_r  <= 4'd0;
        end
      endcase
    end
  end

  demux_out_reg_v #(
    .DATA_W (DATA_W)
  ) u_out_reg (
    .clk    (i_clk),
    .rst    (i_rst),
    .load   (accept_s),
    .retire (retire_s),
    .d      (i_a),
    .q      (o_data),
    .full   (full_s)
  );

  assign o_a_ready = a_ready_s;
  assign o_code    = code_r;
  assign o_valid   = full_s ? code_r : 4'd0;
  assign o_busy    = (state_r != ST_IDLE);
  assign o_err     = err_r;

endmodule

// File: tb/tb_demux_1_4_ctrl_v.sv
// Bench for demux_1_4_ctrl_v: cycle table for fixed/illegal select,
// directed round-robin, backpressure and reset sequences, then random
// traffic checked against a transaction-level destination model.
module tb_demux_1_4_ctrl_v;

  localparam int DATA_W    = 1;
  localparam int BURST_LEN = 4;
  localparam int CNT_W     = 8;

  logic       clk;
  logic       rst;
  logic       mode;
  logic [3:0] sel_code;
  logic       a_valid;
  logic       a;
  logic       a_last;
  logic       a_ready;
  logic [3:0] code;
  logic       data;
  logic [3:0] valid;
  logic [3:0] ready;
  logic       busy;
  logic       err;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       mode;
    logic [3:0] sel;
    logic       av;
    logic       a;
    logic       last;
    logic [3:0] rdy;
    logic       e_ar;
    logic [3:0] e_code;
    logic [3:0] e_valid;
    logic       e_data;
    logic       e_busy;
    logic       e_err;
  } vec_t;

  typedef struct {
    logic [3:0] dest;
    logic       d;
  } beat_t;

  vec_t  vt[14];
  beat_t exp_q[$];
  int    m_ptr;
  int    m_cnt;

  demux_1_4_ctrl_v #(
    .DATA_W    (DATA_W),
    .BURST_LEN (BURST_LEN),
    .CNT_W     (CNT_W)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_mode     (mode),
    .i_sel_code (sel_code),
    .i_a_valid  (a_valid),
    .i_a        (a),
    .i_a_last   (a_last),
    .o_a_ready  (a_ready),
    .o_code     (code),
    .o_data     (data),
    .o_valid    (valid),
    .i_ready    (ready),
    .o_busy     (busy),
    .o_err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Transaction-level model: every accepted beat is bound to the destination
  // the burst rules give, and every retired beat must match the oldest one.
  task automatic monitor_cycle();
    beat_t b;
    if ((valid & ready) != 4'd0) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rand_retire: beat on %b with nothing expected", valid);
      end else begin
        b = exp_q.pop_front();
        check("rand_dest", 32'(valid), 32'(b.dest));
        check("rand_data", 32'(data), 32'(b.d));
      end
    end
    if (a_ready && a_valid) begin
      b.dest = 4'(1 << m_ptr);
      b.d    = a;
      exp_q.push_back(b);
      m_cnt++;
      if (a_last || m_cnt == BURST_LEN) begin
        m_ptr = (m_ptr + 1) % 4;
        m_cnt = 0;
      end
    end
  endtask

  task automatic wait_idle(input string name);
    int w = 0;
    while (busy && w < 100) begin
      @(negedge clk);
      w++;
    end
    check(name, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [3:0] rv[$];
    logic       rd[$];
    int         rc[$];
    logic       sent[20];
    int         acc;
    int         w;
    int         got;

    // mode, sel, av, a, last, rdy | a_ready, code, valid, data, busy, err
    vt[0]  = '{1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 4'b0100, 1'b1, 1'b1, 1'b0, 4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{1'b1, 4'b0100, 1'b1, 1'b1, 1'b0, 4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0};
    vt[3]  = '{1'b1, 4'b0100, 1'b1, 1'b1, 1'b0, 4'b1111, 1'b1, 4'b0100, 4'b0000, 1'b0, 1'b1, 1'b0};
    vt[4]  = '{1'b1, 4'b0100, 1'b1, 1'b0, 1'b1, 4'b1111, 1'b1, 4'b0100, 4'b0100, 1'b1, 1'b1, 1'b0};
    vt[5]  = '{1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b0, 4'b0100, 4'b0100, 1'b0, 1'b1, 1'b0};
    vt[6]  = '{1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{1'b1, 4'b0110, 1'b1, 1'b1, 1'b0, 4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0};
    vt[8]  = '{1'b1, 4'b0110, 1'b1, 1'b1, 1'b0, 4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0};
    vt[9]  = '{1'b1, 4'b0001, 1'b1, 1'b1, 1'b0, 4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1};
    vt[10] = '{1'b1, 4'b0001, 1'b1, 1'b1, 1'b0, 4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1};
    vt[11] = '{1'b1, 4'b0001, 1'b1, 1'b1, 1'b1, 4'b1111, 1'b1, 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b1};
    vt[12] = '{1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b0, 4'b0001, 4'b0001, 1'b1, 1'b1, 1'b1};
    vt[13] = '{1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1};

    rst      = 1'b1;
    mode     = 1'b0;
    sel_code = 4'b0000;
    a_valid  = 1'b0;
    a        = 1'b0;
    a_last   = 1'b0;
    ready    = 4'b1111;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Fixed-mode burst, then illegal select followed by a legal one
    for (int i = 0; i < 14; i++) begin
      mode     = vt[i].mode;
      sel_code = vt[i].sel;
      a_valid  = vt[i].av;
      a        = vt[i].a;
      a_last   = vt[i].last;
      ready    = vt[i].rdy;
      #1;
      check($sformatf("vec%0d_a_ready", i), 32'(a_ready), 32'(vt[i].e_ar));
      check($sformatf("vec%0d_code", i),    32'(code),    32'(vt[i].e_code));
      check($sformatf("vec%0d_valid", i),   32'(valid),   32'(vt[i].e_valid));
      check($sformatf("vec%0d_data", i),    32'(data),    32'(vt[i].e_data));
      check($sformatf("vec%0d_busy", i),    32'(busy),    32'(vt[i].e_busy));
      check($sformatf("vec%0d_err", i),     32'(err),     32'(vt[i].e_err));
      @(negedge clk);
    end

    // Round-robin: 20 continuous beats -> bursts on 0,1,2,3,0
    mode     = 1'b0;
    sel_code = 4'b0110;
    a_last   = 1'b0;
    ready    = 4'b1111;
    for (int k = 0; k < 20; k++) sent[k] = 1'($urandom_range(0, 1));
    acc = 0;
    for (int c = 0; c < 300 && (acc < 20 || busy); c++) begin
      a_valid = (acc < 20);
      a       = (acc < 20) ? sent[acc] : 1'b0;
      #1;
      if ((valid & ready) != 4'd0) begin
        rv.push_back(valid);
        rd.push_back(data);
        rc.push_back(c);
      end
      if (a_ready && a_valid) acc++;
      @(negedge clk);
    end
    a_valid = 1'b0;
    check("rr_beats", 32'(rv.size()), 32'd20);
    for (int k = 0; k < 20 && k < rv.size(); k++) begin
      check($sformatf("rr_dest%0d", k), 32'(rv[k]), 32'(1 << ((k / 4) % 4)));
      check($sformatf("rr_data%0d", k), 32'(rd[k]), 32'(sent[k]));
      if (k % 4 != 0) check($sformatf("rr_gap%0d", k), 32'(rc[k] - rc[k-1]), 32'd1);
    end

    // Backpressure on destination 1 (pointer is 1 after five bursts)
    ready   = 4'b1101;
    a_valid = 1'b1;
    a       = 1'b1;
    w = 0;
    #1;
    while (valid == 4'd0 && w < 20) begin
      @(negedge clk);
      #1;
      w++;
    end
    check("bp_armed", 32'(valid), 32'(4'b0010));
    a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ready = (i % 2 == 1) ? 4'b1101 : 4'b1100;
      #1;
      check($sformatf("bp_valid%0d", i), 32'(valid), 32'(4'b0010));
      check($sformatf("bp_data%0d", i), 32'(data), 32'd1);
      check($sformatf("bp_ready%0d", i), 32'(a_ready), 32'd0);
    end
    @(negedge clk);
    ready  = 4'b1111;
    a_last = 1'b1;
    #1;
    check("bp_release_ready", 32'(a_ready), 32'd1);
    @(negedge clk);
    a_valid = 1'b0;
    a_last  = 1'b0;
    #1;
    check("bp_next_valid", 32'(valid), 32'(4'b0010));
    check("bp_next_data", 32'(data), 32'd0);
    wait_idle("bp_idle");

    // Reset mid-burst with the register holding the 2nd beat (dest 2)
    @(negedge clk);
    acc = 0;
    w   = 0;
    while (acc < 2 && w < 20) begin
      a_valid = 1'b1;
      a       = acc[0] ? 1'b0 : 1'b1;
      #1;
      if (a_ready && a_valid) acc++;
      @(negedge clk);
      w++;
    end
    a_valid = 1'b0;
    #1;
    check("rst_pre_valid", 32'(valid), 32'(4'b0100));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_code", 32'(code), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_a_ready", 32'(a_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    a_valid = 1'b1;
    a_last  = 1'b1;
    w = 0;
    #1;
    while (valid == 4'd0 && w < 20) begin
      @(negedge clk);
      #1;
      w++;
    end
    check("rst_next_dest", 32'(valid), 32'(4'b0001));
    a_valid = 1'b0;
    a_last  = 1'b0;
    wait_idle("rst_idle");

    // Random round-robin traffic against the destination model
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    m_ptr = 0;
    m_cnt = 0;
    exp_q.delete();
    for (int c = 0; c < 3000; c++) begin
      a_valid  = ($urandom_range(0, 3) != 0);
      a        = 1'($urandom_range(0, 1));
      a_last   = ($urandom_range(0, 5) == 0);
      ready    = 4'($urandom_range(0, 15));
      sel_code = 4'($urandom_range(0, 15));
      #1;
      check("rand_valid_onehot", 32'(valid & (valid - 4'd1)), 32'd0);
      check("rand_code_onehot", 32'(code & (code - 4'd1)), 32'd0);
      monitor_cycle();
      @(negedge clk);
    end
    got = 0;
    for (int c = 0; c < 200; c++) begin
      a_valid = (got == 0);
      a_last  = 1'b1;
      a       = 1'($urandom_range(0, 1));
      ready   = 4'b1111;
      #1;
      if (!busy && got != 0) break;
      if (a_ready && a_valid) got = 1;
      monitor_cycle();
      @(negedge clk);
    end
    a_valid = 1'b0;
    check("rand_drained", 32'(exp_q.size()), 32'd0);
    check("rand_idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
